// File: rtl/ib_lut_update_ctrl_if.sv
// LUT source stream handshake for ib_lut_update_ctrl.
// master = LUT source, slave = update controller.
interface ib_lut_update_ctrl_if #(
  parameter int DATA_W = 6
) ();
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;

  modport master (
    output src_valid,
    output src_data,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_data,
    output src_ready
  );
endinterface

// File: rtl/ib_lut_update_ctrl.sv
// IB-VNU LUT reload sequencer for the two-page, dual-replicate LUT RAM.
// Optional: define IB_LUT_STALL_CNT_EN to add the stall_cycles counter.
module ib_lut_update_ctrl #(
  parameter int QUAN_SIZE     = 3,
  parameter int ENTRY_ADDR    = 5,
  parameter int LUT_PORT_SIZE = 3,
  parameter int BANK_NUM      = 1,
  parameter int ITER_MAX      = 8,
  parameter int ITER_W        = $clog2(ITER_MAX + 1)
) (
  input  logic                              write_clk,
  input  logic                              rstn,
  input  logic                              start,
  ib_lut_update_ctrl_if.slave               src,
  input  logic                              iter_done,
  output logic                              read_addr_offset,
  output logic                              lut_ready,
  output logic                              dp_stall,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram_replicate_0,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram_replicate_1,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_0,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
  output logic                              ib_ram_we,
  output logic [ITER_W-1:0]                 iter_cnt,
  output logic                              busy,
  output logic                              done
`ifdef IB_LUT_STALL_CNT_EN
  ,
  output logic [15:0]                       stall_cycles
`endif
);

  localparam int LW = LUT_PORT_SIZE * BANK_NUM;
  localparam int BW = ENTRY_ADDR - 2;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITER_MAX - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    LOAD,
    WAIT_SWAP,
    LAST
  } state_t;

  state_t          state;
  logic [BW-1:0]   beat;
  logic            pending;
  logic            accept;
  logic            last_beat;
  logic [ITER_W-1:0] iter_nxt;

  assign src.src_ready = (state == PRELOAD) || (state == LOAD);
  assign accept        = src.src_valid & src.src_ready;
  assign last_beat     = accept && (beat == '1);
  assign iter_nxt      = iter_cnt + ITER_W'(1);
  assign busy          = (state != IDLE);
  assign dp_stall      = pending;

  // Register accepted beats into the page not being read.
  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      ib_ram_we                 <= 1'b0;
      page_addr_ram_replicate_0 <= '0;
      page_addr_ram_replicate_1 <= '0;
      ram_write_data_0          <= '0;
      ram_write_data_1          <= '0;
      beat                      <= '0;
    end else begin
      ib_ram_we <= accept;
      if (accept) begin
        page_addr_ram_replicate_0 <= {~read_addr_offset, beat, 1'b0};
        page_addr_ram_replicate_1 <= {~read_addr_offset, beat, 1'b1};
        ram_write_data_0          <= src.src_data[LW-1:0];
        ram_write_data_1          <= src.src_data[2*LW-1:LW];
        beat                      <= beat + BW'(1);
      end
    end
  end

  // Frame-group sequencing and page swaps at iteration boundaries.
  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      state            <= IDLE;
      read_addr_offset <= 1'b0;
      lut_ready        <= 1'b0;
      pending          <= 1'b0;
      iter_cnt         <= '0;
      done             <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) state <= PRELOAD;
        end
        PRELOAD: begin
          if (last_beat) begin
            read_addr_offset <= ~read_addr_offset;
            lut_ready        <= 1'b1;
            iter_cnt         <= '0;
            state            <= (ITER_MAX == 1) ? LAST : LOAD;
          end
        end
        LOAD: begin
          if (last_beat) begin
            if (pending || iter_done) begin
              read_addr_offset <= ~read_addr_offset;
              iter_cnt         <= iter_nxt;
              pending          <= 1'b0;
              state            <= (iter_nxt == ITER_LAST) ? LAST : LOAD;
            end else begin
              state <= WAIT_SWAP;
            end
          end else if (iter_done) begin
            pending <= 1'b1;
          end
        end
        WAIT_SWAP: begin
          if (iter_done) begin
            read_addr_offset <= ~read_addr_offset;
            iter_cnt         <= iter_nxt;
            state            <= (iter_nxt == ITER_LAST) ? LAST : LOAD;
          end
        end
        LAST: begin
          if (iter_done) begin
            done      <= 1'b1;
            lut_ready <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IB_LUT_STALL_CNT_EN
  // Saturating count of stalled cycles, cleared when a group starts.
  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      stall_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cycles <= '0;
    end else if (pending && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ib_lut_update_ctrl.sv
// Directed bench for ib_lut_update_ctrl.
// Stall counter checks run when IB_LUT_STALL_CNT_EN is defined.
module tb_ib_lut_update_ctrl;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       iter_done;
  logic       read_addr_offset;
  logic       lut_ready;
  logic       dp_stall;
  logic [4:0] addr0;
  logic [4:0] addr1;
  logic [2:0] wd0;
  logic [2:0] wd1;
  logic       we;
  logic [3:0] iter_cnt;
  logic       busy;
  logic       done;
`ifdef IB_LUT_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  ib_lut_update_ctrl_if #(.DATA_W(6)) src_if ();

  ib_lut_update_ctrl dut (
    .write_clk                 (clk),
    .rstn                      (rstn),
    .start                     (start),
    .src                       (src_if.slave),
    .iter_done                 (iter_done),
    .read_addr_offset          (read_addr_offset),
    .lut_ready                 (lut_ready),
    .dp_stall                  (dp_stall),
    .page_addr_ram_replicate_0 (addr0),
    .page_addr_ram_replicate_1 (addr1),
    .ram_write_data_0          (wd0),
    .ram_write_data_1          (wd1),
    .ib_ram_we                 (we),
    .iter_cnt                  (iter_cnt),
    .busy                      (busy),
    .done                      (done)
`ifdef IB_LUT_STALL_CNT_EN
    ,
    .stall_cycles              (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(logic [5:0] d, logic idn);
    src_if.src_valid = 1'b1;
    src_if.src_data  = d;
    iter_done        = idn;
    tick();
    src_if.src_valid = 1'b0;
    iter_done        = 1'b0;
  endtask

  task automatic pulse_done();
    iter_done = 1'b1;
    tick();
    iter_done = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rstn             = 1'b0;
    start            = 1'b0;
    iter_done        = 1'b0;
    src_if.src_valid = 1'b0;
    src_if.src_data  = '0;
    tick();
    tick();

    chk("rst_busy", 32'(busy), 0);
    chk("rst_off", 32'(read_addr_offset), 0);
    chk("rst_lutrdy", 32'(lut_ready), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_srdy", 32'(src_if.src_ready), 0);
    chk("rst_stall", 32'(dp_stall), 0);
    chk("rst_iter", 32'(iter_cnt), 0);
    chk("rst_done", 32'(done), 0);

    rstn = 1'b1;
    pulse_done();
    chk("idle_ign_busy", 32'(busy), 0);
    chk("idle_ign_off", 32'(read_addr_offset), 0);

    pulse_start();
    chk("start_busy", 32'(busy), 1);
    chk("start_srdy", 32'(src_if.src_ready), 1);
    chk("start_lutrdy", 32'(lut_ready), 0);

    for (int k = 0; k < 8; k++) begin
      beat(6'h2A, 1'b0);
      chk("pre_we", 32'(we), 1);
      chk("pre_a0", 32'(addr0), 32'(16 + 2 * k));
      chk("pre_a1", 32'(addr1), 32'(17 + 2 * k));
      chk("pre_d0", 32'(wd0), 2);
      chk("pre_d1", 32'(wd1), 5);
      if (k < 7) chk("pre_off_hold", 32'(read_addr_offset), 0);
    end
    chk("pre_off", 32'(read_addr_offset), 1);
    chk("pre_lutrdy", 32'(lut_ready), 1);
    chk("pre_iter", 32'(iter_cnt), 0);
    chk("pre_srdy", 32'(src_if.src_ready), 1);
    tick();
    chk("idle_we", 32'(we), 0);

    for (int k = 0; k < 3; k++) begin
      beat(6'h1C, 1'b0);
      chk("ld_a0", 32'(addr0), 32'(2 * k));
      chk("ld_d0", 32'(wd0), 4);
      chk("ld_d1", 32'(wd1), 3);
    end
    pulse_done();
    chk("pend_stall", 32'(dp_stall), 1);
    chk("pend_off", 32'(read_addr_offset), 1);
    repeat (7) tick();
    chk("pend_hold", 32'(dp_stall), 1);
    chk("pend_lutrdy", 32'(lut_ready), 1);
    for (int k = 3; k < 8; k++) begin
      beat(6'h1C, 1'b0);
      if (k == 3) chk("ld_a0_b3", 32'(addr0), 6);
      if (k < 7) begin
        chk("pend_stall_b", 32'(dp_stall), 1);
        chk("pend_off_b", 32'(read_addr_offset), 1);
      end
    end
    chk("pend_swap_off", 32'(read_addr_offset), 0);
    chk("pend_swap_iter", 32'(iter_cnt), 1);
    chk("pend_clear", 32'(dp_stall), 0);
`ifdef IB_LUT_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cycles), 12);
`endif

    for (int k = 0; k < 7; k++) begin
      beat(6'h07, 1'b0);
      if (k == 0) chk("co_a0", 32'(addr0), 16);
    end
    chk("co_stall_pre", 32'(dp_stall), 0);
    beat(6'h07, 1'b1);
    chk("co_off", 32'(read_addr_offset), 1);
    chk("co_iter", 32'(iter_cnt), 2);
    chk("co_stall", 32'(dp_stall), 0);
    chk("co_d0", 32'(wd0), 7);
    chk("co_d1", 32'(wd1), 0);

    for (int k = 0; k < 8; k++) beat(6'h15, 1'b0);
    chk("ws_off", 32'(read_addr_offset), 1);
    chk("ws_iter", 32'(iter_cnt), 2);
    chk("ws_srdy", 32'(src_if.src_ready), 0);
    tick();
    chk("ws_we", 32'(we), 0);
    pulse_done();
    chk("ws_swap_off", 32'(read_addr_offset), 0);
    chk("ws_swap_iter", 32'(iter_cnt), 3);
    chk("ws_swap_srdy", 32'(src_if.src_ready), 1);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) beat(6'h33, 1'b0);
      pulse_done();
    end
    chk("last_iter", 32'(iter_cnt), 7);
    chk("last_srdy", 32'(src_if.src_ready), 0);
    chk("last_lutrdy", 32'(lut_ready), 1);
    chk("last_off", 32'(read_addr_offset), 0);
    chk("last_busy", 32'(busy), 1);
    pulse_done();
    chk("end_done", 32'(done), 1);
    chk("end_lutrdy", 32'(lut_ready), 0);
    chk("end_busy", 32'(busy), 0);
    tick();
    chk("end_done_low", 32'(done), 0);

    pulse_start();
`ifdef IB_LUT_STALL_CNT_EN
    chk("stall_clr", 32'(stall_cycles), 0);
`endif
    for (int k = 0; k < 8; k++) beat(6'h2A, 1'b0);
    chk("g2_off", 32'(read_addr_offset), 1);
    for (int k = 0; k < 5; k++) beat(6'h2A, 1'b0);
    chk("g2_a0_b5", 32'(addr0), 8);
    rstn = 1'b0;
    tick();
    chk("mr_busy", 32'(busy), 0);
    chk("mr_off", 32'(read_addr_offset), 0);
    chk("mr_lutrdy", 32'(lut_ready), 0);
    chk("mr_we", 32'(we), 0);
    chk("mr_a0", 32'(addr0), 0);
    chk("mr_d0", 32'(wd0), 0);
    chk("mr_iter", 32'(iter_cnt), 0);
    chk("mr_srdy", 32'(src_if.src_ready), 0);
    rstn = 1'b1;
    pulse_start();
    beat(6'h2A, 1'b0);
    chk("rl_a0", 32'(addr0), 16);
    chk("rl_a1", 32'(addr1), 17);
    chk("rl_we", 32'(we), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
